ula_result_bcd: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the 4-bit ULA result mux and upstream of the 7-segment decoders.
- Captures the 8-bit ULA result together with its four flags.
- Converts the result to three BCD digits (hundreds/tens/units) with a shift-and-add-3 (double-dabble) engine, one bit per clock.
- Holds the converted digits and flags stable for the display decoders (HEX2/HEX1/HEX0), so products up to 225 display in decimal.

---
 rtl/ula_pkg.sv | 20 ++
 rtl/ula_result_bcd_add3.sv | 10 +
 rtl/ula_result_bcd.sv | 107 ++++++++++
 tb/tb_ula_result_bcd.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared state encoding, flag indices and helpers for the ULA result path
package ula_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_OV   = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_ERR  = 3;

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/ula_result_bcd_add3.sv
// rtl/ula_result_bcd_add3.sv - double-dabble digit corrector (in >= 5 ? in + 3 : in)
module bcd_add3_digit (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Wraps within 4 bits by construction; no carry leaves the digit.
  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/ula_result_bcd.sv
// rtl/ula_result_bcd.sv - one-bit-per-clock binary to BCD converter feeding the HEX decoders
import ula_pkg::*;

module ula_result_bcd #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     result_in,
  input  logic [3:0]            flags_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [3:0]            flags_out,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  if (pow10(DIGITS) <= (longint'(1) << DATA_W) - 1) begin : g_bad_params
    $error("ula_result_bcd: DIGITS too small to hold 2^DATA_W-1");
  end

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] bin_sh_q, bin_sh_d;
  logic [3:0]        flag_hold_q, flag_hold_d;
  logic [BCD_W-1:0]  scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [3:0]        flags_q, flags_d;

  logic [BCD_W-1:0]  scratch_corr;
  logic [BCD_W-1:0]  scratch_shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_in  (scratch_q[4*g +: 4]),
      .digit_out (scratch_corr[4*g +: 4])
    );
  end

  // Correct first, then shift; the binary MSB lands in units bit 0.
  assign scratch_shifted = {scratch_corr[BCD_W-2:0], bin_sh_q[DATA_W-1]};

  always_comb begin
    state_d     = state_q;
    bin_sh_d    = bin_sh_q;
    flag_hold_d = flag_hold_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    flags_d     = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          bin_sh_d    = result_in;
          flag_hold_d = flags_in;
          scratch_d   = '0;
          cnt_d       = CNT_W'(DATA_W);
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = scratch_shifted;
        bin_sh_d  = {bin_sh_q[DATA_W-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scratch_shifted;
          flags_d = flag_hold_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bin_sh_q    <= '0;
      flag_hold_q <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      bin_sh_q    <= bin_sh_d;
      flag_hold_q <= flag_hold_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign bcd_out   = bcd_q;
  assign flags_out = flags_q;

endmodule

// File: tb/tb_ula_result_bcd.sv
// tb/tb_ula_result_bcd.sv - directed table-driven bench for ula_result_bcd
module tb_ula_result_bcd;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  result_in;
  logic [3:0]  flags_in;
  logic [11:0] bcd_out;
  logic [3:0]  flags_out;
  logic        out_valid;
  logic        busy;

  int checks;
  int failures;

  ula_result_bcd #(.DATA_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result_in (result_in),
    .flags_in  (flags_in),
    .bcd_out   (bcd_out),
    .flags_out (flags_out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  result;
    logic [3:0]  flags;
    logic [11:0] exp_bcd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] dec_model(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic run_conv(input logic [7:0] r, input logic [3:0] f, input logic [11:0] exp, input string name);
    int lat;
    bit seen;
    @(negedge clk);
    result_in = r;
    flags_in  = f;
    in_valid  = 1'b1;
    chk({name, "_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'd8);
    chk({name, "_bcd"}, 32'(bcd_out), 32'(exp));
    chk({name, "_flags"}, 32'(flags_out), 32'(f));
    @(posedge clk); #1;
    chk({name, "_pulse_once"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[7];
  int acc_cyc[$];
  logic [11:0] exp_q[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    result_in = '0;
    flags_in  = '0;

    vecs[0] = '{8'hE1, 4'b0000, 12'h225};
    vecs[1] = '{8'd0,  4'b0100, 12'h000};
    vecs[2] = '{8'd9,  4'b0001, 12'h009};
    vecs[3] = '{8'd10, 4'b0010, 12'h010};
    vecs[4] = '{8'd99, 4'b1000, 12'h099};
    vecs[5] = '{8'd255,4'b0011, 12'h255};
    vecs[6] = '{8'd128,4'b1010, 12'h128};

    #2;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_bcd", 32'(bcd_out), 32'h000);
    chk("idle_flags", 32'(flags_out), 32'd0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++)
      run_conv(vecs[i].result, vecs[i].flags, vecs[i].exp_bcd, $sformatf("vec%0d", i));

    // in_valid held high, result_in changing every cycle
    flags_in = 4'b1001;
    for (int cyc = 0; cyc < 32; cyc++) begin
      @(negedge clk);
      result_in = 8'(3 + cyc * 7);
      in_valid  = 1'b1;
      chk($sformatf("stream_ready_vs_busy%0d", cyc), 32'(in_ready), 32'(!busy));
      if (in_ready) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(dec_model(3 + cyc * 7));
      end
      @(posedge clk); #1;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("stream_unexpected_valid", 32'd1, 32'd0);
        else chk($sformatf("stream_bcd%0d", cyc), 32'(bcd_out), 32'(exp_q.pop_front()));
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      if (out_valid) chk("stream_bcd_tail", 32'(bcd_out), 32'(exp_q.pop_front()));
    end
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("stream_acc_count", 32'(acc_cyc.size()), 32'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("stream_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd10);
    chk("stream_flags", 32'(flags_out), 32'b1001);
    repeat (3) @(posedge clk);

    // reset during the 4th SHIFT cycle of 8'h80
    @(negedge clk);
    result_in = 8'h80;
    flags_in  = 4'b0110;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd_out), 32'h000);
    chk("abort_flags", 32'(flags_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        if (out_valid) pulses++;
        if (k == 1) begin
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
      chk("abort_no_pulse", 32'(pulses), 32'd0);
    end
    run_conv(8'h80, 4'b0101, 12'h128, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
